hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter REG_ADDR_W, default 5, SHALL set the register-address width.
REQ-002 Parameter NUM_SRC, default 2, SHALL set the number of source operands per instruction (index 0 = Rs, 1 = Rt).
REQ-003 Parameter CNT_W, default 16, SHALL set the statistics-counter width.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-006 Port src_id, input, NUM_SRC*REG_ADDR_W bits, SHALL carry the ID-stage source addresses, slot i at bits [i*REG_ADDR_W +: REG_ADDR_W].
REQ-007 Ports regwrite_id_ex (1), memread_id_ex (1), rd_id_ex (REG_ADDR_W), inputs, SHALL describe the instruction in EX.
REQ-008 Ports regwrite_ex_mem (1), rd_ex_mem (REG_ADDR_W), inputs, SHALL describe the instruction in MEM.
REQ-009 Port flush, input, 1 bit, SHALL request that the instruction entering EX be squashed.
REQ-010 Port clr_cnt, input, 1 bit, SHALL zero both statistics counters.
REQ-011 Port fwd_sel, output, 2*NUM_SRC bits, registered, SHALL give the per-source forward select for the instruction now in EX, slot i at [2i+1:2i].
REQ-012 Port stall, output, 1 bit, combinational, SHALL hold PC and IF/ID and insert a bubble into ID/EX.
REQ-013 Ports stall_cnt and fwd_cnt, outputs, CNT_W bits each, SHALL count stall cycles and forwarded operands.

Function
REQ-014 Select encoding SHALL be: 2'b00 register file, 2'b10 EX/MEM result, 2'b01 MEM/WB result.
REQ-015 Per slot i, next select SHALL be 2'b10 when regwrite_id_ex=1, rd_id_ex!=0, rd_id_ex==src_i and memread_id_ex=0.
REQ-016 Otherwise, next select SHALL be 2'b01 when regwrite_ex_mem=1, rd_ex_mem!=0, rd_ex_mem==src_i; otherwise 2'b00. The EX match SHALL win over the MEM match.
REQ-017 fwd_sel SHALL be registered at the rising edge, one cycle of latency, aligned with the ID/EX register.
REQ-018 Load-use hazard SHALL exist when memread_id_ex=1, regwrite_id_ex=1, rd_id_ex!=0 and rd_id_ex equals any src_i.
REQ-019 The stall FSM SHALL have states RUN and BUBBLE, with reset state RUN.
REQ-020 In RUN, stall SHALL equal the load-use hazard; when stall=1 the FSM SHALL go to BUBBLE.
REQ-021 In BUBBLE, stall SHALL be 0 and the FSM SHALL return to RUN next cycle: exactly one bubble per load-use.
REQ-022 When stall=1 or flush=1, the registered fwd_sel SHALL load all 2'b00 (bubble).
REQ-023 flush SHALL force stall=0 in the same cycle and force the next state to RUN, even from BUBBLE.
REQ-024 stall_cnt SHALL add 1 in each cycle stall=1.
REQ-025 fwd_cnt SHALL add the number of slots whose next select is non-zero, only in cycles where fwd_sel is loaded without a bubble.
REQ-026 Both counters SHALL saturate at 2^CNT_W-1 and never wrap; clr_cnt SHALL take priority over increment.
REQ-027 A source address of 0 SHALL never forward or stall.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL set fwd_sel=0, FSM=RUN, stall_cnt=0 and fwd_cnt=0.
REQ-029 While rst=1, stall SHALL be 0.
REQ-030 rst asserted in BUBBLE SHALL discard the pending bubble state.

Structure
REQ-031 Package fwd_pkg SHALL hold the select constants FWD_NONE, FWD_MEM and FWD_WB, and the FSM state type.
REQ-032 One sub-module, fwd_src_cmp, SHALL compute the next select and the hazard flag for one source; it SHALL be instantiated NUM_SRC times.

Verification
REQ-033 Stimulus rd_id_ex=1, regwrite_id_ex=1, memread_id_ex=0, src0=1 -> after one edge, fwd_sel[1:0]=2'b10; stall=0.
REQ-034 Stimulus rd_id_ex=8, rd_ex_mem=6, regwrite_ex_mem=1, src1=6 -> fwd_sel[3:2]=2'b01; with rd_id_ex=6 and regwrite_id_ex=1 instead -> 2'b10.
REQ-035 Stimulus load with rd_id_ex=3, src0=3 -> stall=1 for exactly one cycle; fwd_sel=0 (bubble); next cycle with rd_ex_mem=3 -> fwd_sel[1:0]=2'b01; stall_cnt=1.
REQ-036 Stimulus rd=0 with regwrite=1 and src=0 on all stages -> fwd_sel=0 and stall=0.
REQ-037 Stimulus flush asserted during a load-use hazard -> stall=0, FSM=RUN, fwd_sel=0; rst asserted in BUBBLE -> all outputs 0 next cycle.
REQ-038 Stimulus with CNT_W=2 and 5 stall events -> stall_cnt saturates at 3; clr_cnt together with a stall -> stall_cnt=0.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared constants and types for the forwarding / load-use hazard unit.
package fwd_pkg;

    // Operand source selects as seen by the EX-stage operand muxes.
    localparam logic [1:0] FWD_NONE = 2'b00;  // register file
    localparam logic [1:0] FWD_MEM  = 2'b10;  // EX/MEM result
    localparam logic [1:0] FWD_WB   = 2'b01;  // MEM/WB result

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } stall_state_t;

endpackage

// File: rtl/fwd_src_cmp.sv
// Forward select and load-use flag for a single ID-stage source operand.
module fwd_src_cmp #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_src,
    input  logic                  i_regwrite_id_ex,
    input  logic                  i_memread_id_ex,
    input  logic [REG_ADDR_W-1:0] i_rd_id_ex,
    input  logic                  i_regwrite_ex_mem,
    input  logic [REG_ADDR_W-1:0] i_rd_ex_mem,
    output logic [1:0]            o_sel_c,
    output logic                  o_hazard_c
);
    import fwd_pkg::*;

    logic w_src_nz;
    logic w_ex_match;
    logic w_mem_match;

    // A non-zero source that equals rd also guarantees rd is non-zero.
    assign w_src_nz    = (i_src != '0);
    assign w_ex_match  = w_src_nz && i_regwrite_id_ex  && (i_rd_id_ex  == i_src);
    assign w_mem_match = w_src_nz && i_regwrite_ex_mem && (i_rd_ex_mem == i_src);

    // The younger EX producer wins; a load in EX cannot supply data yet.
    always_comb begin
        o_sel_c = FWD_NONE;
        if (w_ex_match && !i_memread_id_ex) begin
            o_sel_c = FWD_MEM;
        end else if (w_mem_match) begin
            o_sel_c = FWD_WB;
        end
    end

    assign o_hazard_c = w_ex_match && i_memread_id_ex;

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding selects, one-bubble load-use stall FSM and saturating statistics.
module hazard_forward_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]  src_id,
    input  logic                           regwrite_id_ex,
    input  logic                           memread_id_ex,
    input  logic [REG_ADDR_W-1:0]          rd_id_ex,
    input  logic                           regwrite_ex_mem,
    input  logic [REG_ADDR_W-1:0]          rd_ex_mem,
    input  logic                           flush,
    input  logic                           clr_cnt,
    output logic [2*NUM_SRC-1:0]           fwd_sel,
    output logic                           stall,
    output logic [CNT_W-1:0]               stall_cnt,
    output logic [CNT_W-1:0]               fwd_cnt
);
    import fwd_pkg::*;

    localparam int unsigned ADD_W = $clog2(NUM_SRC + 1);
    localparam int unsigned SUM_W = CNT_W + ADD_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2*NUM_SRC-1:0] w_next_sel;
    logic [NUM_SRC-1:0]   w_hazard_vec;
    logic [NUM_SRC-1:0]   w_fwd_vec;
    logic                 w_load_use;
    logic                 w_stall;
    logic                 w_bubble;
    logic [ADD_W-1:0]     w_fwd_num;
    logic [SUM_W-1:0]     w_stall_sum;
    logic [SUM_W-1:0]     w_fwd_sum;
    logic [CNT_W-1:0]     w_stall_cnt_nxt;
    logic [CNT_W-1:0]     w_fwd_cnt_nxt;
    stall_state_t         w_state_nxt;

    stall_state_t         r_state;
    logic [2*NUM_SRC-1:0] r_fwd_sel;
    logic [CNT_W-1:0]     r_stall_cnt;
    logic [CNT_W-1:0]     r_fwd_cnt;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_src_cmp #(
            .REG_ADDR_W (REG_ADDR_W)
        ) u_cmp (
            .i_src             (src_id[g*REG_ADDR_W +: REG_ADDR_W]),
            .i_regwrite_id_ex  (regwrite_id_ex),
            .i_memread_id_ex   (memread_id_ex),
            .i_rd_id_ex        (rd_id_ex),
            .i_regwrite_ex_mem (regwrite_ex_mem),
            .i_rd_ex_mem       (rd_ex_mem),
            .o_sel_c           (w_next_sel[2*g +: 2]),
            .o_hazard_c        (w_hazard_vec[g])
        );
        assign w_fwd_vec[g] = |w_next_sel[2*g +: 2];
    end

    assign w_load_use = |w_hazard_vec;

    // Stall FSM: one bubble per load-use; flush squashes and always returns to RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_stall = w_load_use && !flush && !rst;
                if (w_stall) begin
                    w_state_nxt = ST_BUBBLE;
                end
            end
            ST_BUBBLE: w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_RUN;
        endcase
        if (flush) begin
            w_state_nxt = ST_RUN;
        end
    end

    assign w_bubble = w_stall || flush;

    always_comb begin
        w_fwd_num = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            w_fwd_num = w_fwd_num + ADD_W'(w_fwd_vec[i]);
        end
    end

    // Saturating increments computed one carry wider than the counters.
    assign w_stall_sum     = SUM_W'(r_stall_cnt) + SUM_W'(w_stall);
    assign w_fwd_sum       = SUM_W'(r_fwd_cnt) + (w_bubble ? SUM_W'(0) : SUM_W'(w_fwd_num));
    assign w_stall_cnt_nxt = (w_stall_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_stall_sum[CNT_W-1:0];
    assign w_fwd_cnt_nxt   = (w_fwd_sum   > SUM_W'(CNT_MAX)) ? CNT_MAX : w_fwd_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_fwd_sel   <= '0;
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_fwd_sel <= w_bubble ? '0 : w_next_sel;
            if (clr_cnt) begin
                r_stall_cnt <= '0;
                r_fwd_cnt   <= '0;
            end else begin
                r_stall_cnt <= w_stall_cnt_nxt;
                r_fwd_cnt   <= w_fwd_cnt_nxt;
            end
        end
    end

    assign fwd_sel   = r_fwd_sel;
    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;
    assign fwd_cnt   = r_fwd_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed scoreboard bench for hazard_forward_unit built with 2-bit counters.
module tb_hazard_forward_unit;

    localparam int unsigned RW = 5;
    localparam int unsigned NS = 2;
    localparam int unsigned CW = 2;

    localparam logic [3:0] M_ALL = 4'b1111;
    localparam logic [3:0] M_ST  = 4'b0010;

    logic            clk = 1'b0;
    logic            rst;
    logic [NS*RW-1:0] src_id;
    logic            regwrite_id_ex;
    logic            memread_id_ex;
    logic [RW-1:0]   rd_id_ex;
    logic            regwrite_ex_mem;
    logic [RW-1:0]   rd_ex_mem;
    logic            flush;
    logic            clr_cnt;
    logic [2*NS-1:0] fwd_sel;
    logic            stall;
    logic [CW-1:0]   stall_cnt;
    logic [CW-1:0]   fwd_cnt;

    hazard_forward_unit #(
        .REG_ADDR_W (RW),
        .NUM_SRC    (NS),
        .CNT_W      (CW)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .src_id          (src_id),
        .regwrite_id_ex  (regwrite_id_ex),
        .memread_id_ex   (memread_id_ex),
        .rd_id_ex        (rd_id_ex),
        .regwrite_ex_mem (regwrite_ex_mem),
        .rd_ex_mem       (rd_ex_mem),
        .flush           (flush),
        .clr_cnt         (clr_cnt),
        .fwd_sel         (fwd_sel),
        .stall           (stall),
        .stall_cnt       (stall_cnt),
        .fwd_cnt         (fwd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          id;
        logic [3:0]  mask;
        logic [3:0]  sel;
        logic        st;
        logic [1:0]  sc;
        logic [1:0]  fc;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   row_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each expectation is due at the falling edge of the cycle it was issued in.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m_e = q.pop_front();
            if (m_e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL row%0d stale expectation issued cycle %0d seen cycle %0d", m_e.id, m_e.cyc, cyc);
            end else begin
                if (m_e.mask[0]) begin
                    checks++;
                    if (fwd_sel !== m_e.sel) begin
                        errors++;
                        $display("FAIL row%0d fwd_sel got %b exp %b", m_e.id, fwd_sel, m_e.sel);
                    end
                end
                if (m_e.mask[1]) begin
                    checks++;
                    if (stall !== m_e.st) begin
                        errors++;
                        $display("FAIL row%0d stall got %b exp %b", m_e.id, stall, m_e.st);
                    end
                end
                if (m_e.mask[2]) begin
                    checks++;
                    if (stall_cnt !== m_e.sc) begin
                        errors++;
                        $display("FAIL row%0d stall_cnt got %0d exp %0d", m_e.id, stall_cnt, m_e.sc);
                    end
                end
                if (m_e.mask[3]) begin
                    checks++;
                    if (fwd_cnt !== m_e.fc) begin
                        errors++;
                        $display("FAIL row%0d fwd_cnt got %0d exp %0d", m_e.id, fwd_cnt, m_e.fc);
                    end
                end
            end
        end
    end

    // Apply one cycle of inputs, queue what must be observed this cycle, advance.
    task automatic row(input logic r, input logic f, input logic c,
                       input logic rwi, input logic mri, input int rdi,
                       input logic rwm, input int rdm, input int s0, input int s1,
                       input logic [3:0] mask, input logic [3:0] esel, input logic est,
                       input int esc, input int efc);
        exp_t e;
        rst             = r;
        flush           = f;
        clr_cnt         = c;
        regwrite_id_ex  = rwi;
        memread_id_ex   = mri;
        rd_id_ex        = RW'(rdi);
        regwrite_ex_mem = rwm;
        rd_ex_mem       = RW'(rdm);
        src_id          = {RW'(s1), RW'(s0)};
        e.cyc  = cyc;
        e.id   = row_id;
        e.mask = mask;
        e.sel  = esel;
        e.st   = est;
        e.sc   = 2'(esc);
        e.fc   = 2'(efc);
        q.push_back(e);
        row_id++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; clr_cnt = 1'b0;
        regwrite_id_ex = 1'b0; memread_id_ex = 1'b0; rd_id_ex = '0;
        regwrite_ex_mem = 1'b0; rd_ex_mem = '0; src_id = '0;
        repeat (2) @(posedge clk);
        #1;
        //   r  f  c  rwi mri rdi rwm rdm s0 s1  mask   sel      st  sc fc
        row(1, 0, 0, 1,  1,  3,  0,  0,  3, 0,  M_ST,  4'b0000, 0,  0, 0);  // load-use under reset: no stall
        row(0, 0, 0, 0,  0,  0,  0,  0,  0, 0,  M_ALL, 4'b0000, 0,  0, 0);  // reset state
        row(0, 0, 0, 1,  0,  1,  0,  0,  1, 0,  M_ALL, 4'b0000, 0,  0, 0);  // EX forward slot0
        row(0, 0, 0, 0,  0,  0,  0,  0,  0, 0,  M_ALL, 4'b0010, 0,  0, 1);
        row(0, 0, 0, 1,  0,  8,  1,  6,  0, 6,  M_ALL, 4'b0000, 0,  0, 1);  // MEM forward slot1
        row(0, 0, 0, 1,  0,  6,  1,  6,  0, 6,  M_ALL, 4'b0100, 0,  0, 2);  // EX beats MEM
        row(0, 0, 1, 0,  0,  0,  0,  0,  0, 0,  M_ALL, 4'b1000, 0,  0, 3);  // clear counters
        row(0, 0, 0, 1,  0,  5,  1,  7,  7, 5,  M_ALL, 4'b0000, 0,  0, 0);  // both slots forward
        row(0, 0, 0, 0,  0,  0,  0,  0,  0, 0,  M_ALL, 4'b1001, 0,  0, 2);
        row(0, 0, 0, 1,  1,  3,  0,  0,  3, 0,  M_ALL, 4'b0000, 1,  0, 2);  // load-use stall
        row(0, 0, 0, 0,  0,  0,  1,  3,  3, 0,  M_ALL, 4'b0000, 0,  1, 2);  // bubble cycle, load now in MEM
        row(0, 0, 0, 0,  0,  0,  0,  0,  0, 0,  M_ALL, 4'b0001, 0,  1, 3);
        row(0, 0, 0, 1,  1,  4,  0,  0,  0, 4,  M_ALL, 4'b0000, 1,  1, 3);  // persistent hazard
        row(0, 0, 0, 1,  1,  4,  0,  0,  0, 4,  M_ALL, 4'b0000, 0,  2, 3);  // BUBBLE never stalls
        row(0, 0, 0, 1,  1,  4,  0,  0,  0, 4,  M_ALL, 4'b0000, 1,  2, 3);
        row(0, 1, 0, 1,  1,  4,  0,  0,  0, 4,  M_ALL, 4'b0000, 0,  3, 3);  // flush from BUBBLE
        row(0, 1, 0, 1,  1,  4,  0,  0,  0, 4,  M_ALL, 4'b0000, 0,  3, 3);  // flush masks hazard in RUN
        row(0, 0, 0, 1,  1,  4,  0,  0,  0, 4,  M_ALL, 4'b0000, 1,  3, 3);
        row(1, 0, 0, 1,  1,  4,  0,  0,  0, 4,  M_ALL, 4'b0000, 0,  3, 3);  // reset in BUBBLE
        row(0, 0, 0, 1,  1,  4,  0,  0,  0, 4,  M_ALL, 4'b0000, 1,  0, 0);  // back in RUN after reset
        row(0, 0, 0, 0,  0,  0,  0,  0,  0, 0,  M_ALL, 4'b0000, 0,  1, 0);
        row(0, 0, 0, 1,  1,  4,  0,  0,  0, 4,  M_ALL, 4'b0000, 1,  1, 0);
        row(0, 0, 0, 0,  0,  0,  0,  0,  0, 0,  M_ALL, 4'b0000, 0,  2, 0);
        row(0, 0, 0, 1,  1,  4,  0,  0,  0, 4,  M_ALL, 4'b0000, 1,  2, 0);
        row(0, 0, 0, 0,  0,  0,  0,  0,  0, 0,  M_ALL, 4'b0000, 0,  3, 0);
        row(0, 0, 0, 1,  1,  4,  0,  0,  0, 4,  M_ALL, 4'b0000, 1,  3, 0);
        row(0, 0, 0, 0,  0,  0,  0,  0,  0, 0,  M_ALL, 4'b0000, 0,  3, 0);  // saturated at 3
        row(0, 0, 0, 1,  1,  4,  0,  0,  0, 4,  M_ALL, 4'b0000, 1,  3, 0);
        row(0, 0, 0, 0,  0,  0,  0,  0,  0, 0,  M_ALL, 4'b0000, 0,  3, 0);
        row(0, 0, 1, 1,  1,  4,  0,  0,  0, 4,  M_ALL, 4'b0000, 1,  3, 0);  // clear wins over stall
        row(0, 0, 0, 0,  0,  0,  0,  0,  0, 0,  M_ALL, 4'b0000, 0,  0, 0);
        row(0, 0, 0, 1,  1,  0,  1,  0,  0, 0,  M_ALL, 4'b0000, 0,  0, 0);  // r0 load never stalls
        row(0, 0, 0, 1,  0,  0,  1,  0,  0, 0,  M_ALL, 4'b0000, 0,  0, 0);  // r0 never forwards
        row(0, 1, 0, 1,  0,  2,  0,  0,  2, 0,  M_ALL, 4'b0000, 0,  0, 0);  // flush squashes forward
        row(0, 0, 0, 0,  0,  0,  0,  0,  0, 0,  M_ALL, 4'b0000, 0,  0, 0);
        row(0, 0, 0, 1,  0,  5,  1,  7,  7, 5,  M_ALL, 4'b0000, 0,  0, 0);
        row(0, 0, 0, 1,  0,  5,  1,  7,  7, 5,  M_ALL, 4'b1001, 0,  0, 2);
        row(0, 0, 0, 0,  0,  0,  0,  0,  0, 0,  M_ALL, 4'b1001, 0,  0, 3);  // fwd_cnt saturates
        row(0, 0, 0, 0,  0,  0,  0,  0,  0, 0,  M_ALL, 4'b0000, 0,  0, 3);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain %0d expectations left unchecked, exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
